// File: rtl/udp_tx_sched.sv
// udp_tx_sched: issues one ARP/UDP1/UDP2 frame start at a time, ARP strict priority, UDP round-robin.
// Define UDP_TX_SCHED_STATS_EN to build the per-source completed-frame counters.
module udp_tx_sched #(
  parameter int unsigned IFG_CYCLES = 12,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned PW         = 4
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        req_arp,
  input  logic        req_udp1,
  input  logic        req_udp2,
  input  logic        tx_rdy,
  input  logic        tx_wren,
  input  logic        tx_sop,
  input  logic        tx_eop,
  output logic        en_arp,
  output logic        en_udp1,
  output logic        en_udp2,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        timeout_err,
  output logic        req_drop,
  output logic [15:0] frames_arp,
  output logic [15:0] frames_udp1,
  output logic [15:0] frames_udp2
);

  localparam int unsigned TMAX = (TIMEOUT > IFG_CYCLES) ? TIMEOUT : IFG_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TO_VAL   = TW'(TIMEOUT);
  localparam logic [TW-1:0] IFG_LAST = TW'(IFG_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_SOP, S_WAIT_EOP, S_GAP} state_t;

  state_t        state_q;
  logic [PW-1:0] pend_arp_q, pend_u1_q, pend_u2_q;
  logic [PW-1:0] pend_arp_d, pend_u1_d, pend_u2_d;
  logic [TW-1:0] tmr_q, tmr_inc;
  logic          rr_q;
  logic          en_arp_q, en_u1_q, en_u2_q;
  logic [1:0]    grant_q;
  logic          busy_q, to_q, drop_q;

  logic can_issue, iss_arp, iss_u1, iss_u2, drop_d, done, timed_out;

  // A request at saturation is dropped even if the same source issues this cycle.
  function automatic logic [PW-1:0] pend_next(input logic [PW-1:0] c, input logic req,
                                              input logic iss);
    logic inc;
    inc       = req && (c != '1);
    pend_next = c;
    if (inc && !iss)      pend_next = c + 1'b1;
    else if (!inc && iss) pend_next = c - 1'b1;
  endfunction

  always_comb begin
    can_issue = (state_q == S_IDLE) && tx_rdy &&
                ((pend_arp_q != '0) || (pend_u1_q != '0) || (pend_u2_q != '0));
    iss_arp   = can_issue && (pend_arp_q != '0);
    iss_u1    = can_issue && !iss_arp && (pend_u1_q != '0) && ((pend_u2_q == '0) || !rr_q);
    iss_u2    = can_issue && !iss_arp && (pend_u2_q != '0) && ((pend_u1_q == '0) || rr_q);

    pend_arp_d = pend_next(pend_arp_q, req_arp,  iss_arp);
    pend_u1_d  = pend_next(pend_u1_q,  req_udp1, iss_u1);
    pend_u2_d  = pend_next(pend_u2_q,  req_udp2, iss_u2);
    drop_d     = (req_arp  && (pend_arp_q == '1)) ||
                 (req_udp1 && (pend_u1_q  == '1)) ||
                 (req_udp2 && (pend_u2_q  == '1));

    tmr_inc   = tmr_q + 1'b1;
    done      = tx_wren && tx_eop &&
                (((state_q == S_WAIT_SOP) && tx_sop) || (state_q == S_WAIT_EOP));
    timed_out = ((state_q == S_WAIT_SOP) || (state_q == S_WAIT_EOP)) && !done &&
                (tmr_inc == TO_VAL);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q    <= S_IDLE;
      pend_arp_q <= '0;
      pend_u1_q  <= '0;
      pend_u2_q  <= '0;
      tmr_q      <= '0;
      rr_q       <= 1'b0;
      en_arp_q   <= 1'b0;
      en_u1_q    <= 1'b0;
      en_u2_q    <= 1'b0;
      grant_q    <= 2'd0;
      busy_q     <= 1'b0;
      to_q       <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      pend_arp_q <= pend_arp_d;
      pend_u1_q  <= pend_u1_d;
      pend_u2_q  <= pend_u2_d;
      en_arp_q   <= iss_arp;
      en_u1_q    <= iss_u1;
      en_u2_q    <= iss_u2;
      to_q       <= timed_out;
      drop_q     <= drop_d;
      case (state_q)
        S_IDLE: begin
          if (can_issue) begin
            state_q <= S_WAIT_SOP;
            busy_q  <= 1'b1;
            tmr_q   <= '0;
            if (iss_arp) begin
              grant_q <= 2'd1;
            end else if (iss_u1) begin
              grant_q <= 2'd2;
              rr_q    <= 1'b1;
            end else begin
              grant_q <= 2'd3;
              rr_q    <= 1'b0;
            end
          end
        end
        S_WAIT_SOP, S_WAIT_EOP: begin
          if (done || timed_out) begin
            state_q <= S_GAP;
            grant_q <= 2'd0;
            tmr_q   <= '0;
          end else begin
            tmr_q <= tmr_inc;
            if ((state_q == S_WAIT_SOP) && tx_wren && tx_sop) state_q <= S_WAIT_EOP;
          end
        end
        S_GAP: begin
          if (tmr_q == IFG_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            tmr_q <= tmr_inc;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign en_arp      = en_arp_q;
  assign en_udp1     = en_u1_q;
  assign en_udp2     = en_u2_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign timeout_err = to_q;
  assign req_drop    = drop_q;

`ifdef UDP_TX_SCHED_STATS_EN
  logic [15:0] fr_arp_q, fr_u1_q, fr_u2_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      fr_arp_q <= '0;
      fr_u1_q  <= '0;
      fr_u2_q  <= '0;
    end else if (done) begin
      case (grant_q)
        2'd1:    fr_arp_q <= fr_arp_q + 16'd1;
        2'd2:    fr_u1_q  <= fr_u1_q + 16'd1;
        2'd3:    fr_u2_q  <= fr_u2_q + 16'd1;
        default: ;
      endcase
    end
  end

  assign frames_arp  = fr_arp_q;
  assign frames_udp1 = fr_u1_q;
  assign frames_udp2 = fr_u2_q;
`else
  assign frames_arp  = '0;
  assign frames_udp1 = '0;
  assign frames_udp2 = '0;
`endif

endmodule

// File: tb/tb_udp_tx_sched.sv
// Scoreboard bench for udp_tx_sched: expected pulses queued by stimulus, checked by a monitor.
module tb_udp_tx_sched;

  localparam int TO  = 64;
  localparam int IFG = 12;
`ifdef UDP_TX_SCHED_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  localparam logic [4:0] EV_ARP  = 5'b10000;
  localparam logic [4:0] EV_U1   = 5'b01000;
  localparam logic [4:0] EV_U2   = 5'b00100;
  localparam logic [4:0] EV_TO   = 5'b00010;
  localparam logic [4:0] EV_DROP = 5'b00001;

  logic        clk = 1'b0;
  logic        srst, req_arp, req_udp1, req_udp2, tx_rdy, tx_wren, tx_sop, tx_eop;
  logic        en_arp, en_udp1, en_udp2, busy, timeout_err, req_drop;
  logic [1:0]  grant;
  logic [15:0] frames_arp, frames_udp1, frames_udp2;

  udp_tx_sched #(.IFG_CYCLES(IFG), .TIMEOUT(TO), .PW(4)) dut (
    .clk(clk), .srst(srst),
    .req_arp(req_arp), .req_udp1(req_udp1), .req_udp2(req_udp2),
    .tx_rdy(tx_rdy), .tx_wren(tx_wren), .tx_sop(tx_sop), .tx_eop(tx_eop),
    .en_arp(en_arp), .en_udp1(en_udp1), .en_udp2(en_udp2),
    .grant(grant), .busy(busy), .timeout_err(timeout_err), .req_drop(req_drop),
    .frames_arp(frames_arp), .frames_udp1(frames_udp1), .frames_udp2(frames_udp2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [4:0] ev;
    logic [1:0] gr;
    bit         chk_gr;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [4:0] ev, input logic [1:0] gr, input bit chk, input int c);
    sb.push_back('{ev: ev, gr: gr, chk_gr: chk, cyc: c});
  endtask

  logic [4:0] mon_obs;
  exp_t       mon_e;
  always @(negedge clk) begin
    mon_obs = {en_arp, en_udp1, en_udp2, timeout_err, req_drop};
    if (!srst && (mon_obs != 5'b0)) begin
      if (sb.size() == 0) begin
        check("unexpected_event", {27'b0, mon_obs}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("event", {27'b0, mon_obs}, {27'b0, mon_e.ev});
        check("event_cycle", cyc, mon_e.cyc);
        if (mon_e.chk_gr) check("event_grant", {30'b0, grant}, {30'b0, mon_e.gr});
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_grant"}, {30'b0, grant}, 0);
    check({tag, "_busy"}, {31'b0, busy}, 0);
    check({tag, "_en"}, {29'b0, en_arp, en_udp1, en_udp2}, 0);
    check({tag, "_flags"}, {30'b0, timeout_err, req_drop}, 0);
  endtask

  task automatic do_reset();
    srst = 1'b1;
    {req_arp, req_udp1, req_udp2, tx_wren, tx_sop, tx_eop} = '0;
    tx_rdy = 1'b1;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    check("reset_frames", {frames_arp, frames_udp1} | {16'b0, frames_udp2}, 0);
    srst = 1'b0;
  endtask

  task automatic pulse(input logic a, input logic u1, input logic u2, output int c);
    c = cyc;
    req_arp = a; req_udp1 = u1; req_udp2 = u2;
    @(negedge clk);
    {req_arp, req_udp1, req_udp2} = '0;
  endtask

  // Drives a frame of 'beats' beats after 'delay' cycles; p = edge at which eop is sampled.
  task automatic frame(input logic [1:0] gr, input int delay, input int beats, output int p);
    repeat (delay) @(negedge clk);
    tx_wren = 1'b1; tx_sop = 1'b1; tx_eop = (beats == 1);
    for (int i = 1; i < beats; i++) begin
      @(negedge clk);
      tx_sop = 1'b0;
      tx_eop = (i == beats - 1);
    end
    check("grant_hold", {30'b0, grant}, {30'b0, gr});
    p = cyc + 1;
    @(negedge clk);
    {tx_wren, tx_sop, tx_eop} = '0;
    check("grant_gap", {30'b0, grant}, 0);
    check("busy_gap", {31'b0, busy}, 1);
  endtask

  task automatic serve(input logic [4:0] ev, input logic [1:0] gr, input int ecyc,
                       input int delay, input int beats, output int p);
    push(ev, gr, 1'b1, ecyc);
    wait_cyc(ecyc);
    frame(gr, delay, beats, p);
  endtask

  task automatic check_gap_end(input int p);
    wait_cyc(p + IFG - 1);
    check("busy_last_gap", {31'b0, busy}, 1);
    @(negedge clk);
    check("busy_after_gap", {31'b0, busy}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int c, p, m;
    srst = 1'b1;
    {req_arp, req_udp1, req_udp2, tx_wren, tx_sop, tx_eop} = '0;
    tx_rdy = 1'b1;
    @(negedge clk);

    // Simultaneous requests: ARP, then UDP1 (rr starts toward UDP1), then UDP2.
    do_reset();
    pulse(1'b1, 1'b1, 1'b1, c);
    serve(EV_ARP, 2'd1, c + 2, 2, 3, p);
    serve(EV_U1, 2'd2, p + IFG + 1, 1, 4, p);
    serve(EV_U2, 2'd3, p + IFG + 1, 0, 1, p);
    check("t2_frames_arp", {16'b0, frames_arp}, STATS);
    check("t2_frames_u1", {16'b0, frames_udp1}, STATS);
    check("t2_frames_u2", {16'b0, frames_udp2}, STATS);
    repeat (20) @(negedge clk);

    // Single UDP1 request, sop at k+3, eop at k+35, then exactly IFG gap cycles.
    do_reset();
    pulse(1'b0, 1'b1, 1'b0, c);
    serve(EV_U1, 2'd2, c + 2, 1, 33, p);
    check("t1_eop_edge", p, c + 36);
    check_gap_end(p);
    check("t1_frames_u1", {16'b0, frames_udp1}, STATS);

    // 17 UDP2 requests while busy: saturate at 15, two drops, then 15 issues.
    do_reset();
    pulse(1'b0, 1'b1, 1'b0, c);
    push(EV_U1, 2'd2, 1'b1, c + 2);
    push(EV_DROP, 2'd0, 1'b0, c + 18);
    push(EV_DROP, 2'd0, 1'b0, c + 19);
    wait_cyc(c + 2);
    req_udp2 = 1'b1;
    repeat (17) @(negedge clk);
    req_udp2 = 1'b0;
    frame(2'd2, 0, 3, p);
    for (int i = 0; i < 15; i++) serve(EV_U2, 2'd3, p + IFG + 1, 0, 1, p);
    repeat (30) @(negedge clk);
    check("t3_idle_busy", {31'b0, busy}, 0);
    check("t3_frames_u2", {16'b0, frames_udp2}, 15 * STATS);

    // No sop: timeout TO cycles after en, then GAP, then the pending UDP2 is served.
    do_reset();
    pulse(1'b0, 1'b1, 1'b1, c);
    push(EV_U1, 2'd2, 1'b1, c + 2);
    push(EV_TO, 2'd0, 1'b1, c + 2 + TO);
    wait_cyc(c + 2 + TO);
    check("t4_busy_gap", {31'b0, busy}, 1);
    serve(EV_U2, 2'd3, c + 2 + TO + IFG + 1, 0, 1, p);
    check("t4_frames_u1", {16'b0, frames_udp1}, 0);
    check("t4_frames_u2", {16'b0, frames_udp2}, STATS);
    repeat (20) @(negedge clk);

    // Reset in WAIT_EOP with 3 pending: everything cleared, no further issues.
    do_reset();
    pulse(1'b0, 1'b1, 1'b0, c);
    push(EV_U1, 2'd2, 1'b1, c + 2);
    wait_cyc(c + 2);
    req_udp2 = 1'b1;
    repeat (3) @(negedge clk);
    req_udp2 = 1'b0;
    tx_wren = 1'b1; tx_sop = 1'b1;
    @(negedge clk);
    tx_wren = 1'b0; tx_sop = 1'b0;
    @(negedge clk);
    srst = 1'b1;
    @(negedge clk);
    check_quiet("t5_after_srst");
    srst = 1'b0;
    repeat (60) @(negedge clk);
    check("t5_still_idle", {31'b0, busy}, 0);

    // tx_rdy low stalls ARP; issue one cycle after it rises; single-beat frame.
    do_reset();
    tx_rdy = 1'b0;
    pulse(1'b1, 1'b0, 1'b0, c);
    repeat (20) @(negedge clk);
    check("t6_stalled", {31'b0, busy}, 0);
    m = cyc;
    tx_rdy = 1'b1;
    serve(EV_ARP, 2'd1, m + 1, 0, 1, p);
    check("t6_frames_arp", {16'b0, frames_arp}, STATS);
    check_gap_end(p);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/udp_tx_sched.md
Name: udp_tx_sched

Overview:
Frame-level scheduler in front of the 3-way UDP/ARP TX arbiter. Takes request pulses from the ARP responder and two UDP senders and queues them in per-source pending counters. Issues one en_arp/en_udp1/en_udp2 start pulse at a time, then waits for the full frame (sop..eop) on the MAC-side TX bus plus an inter-frame gap before it issues the next. ARP has strict priority; UDP1 and UDP2 alternate round-robin.

Parameters:
IFG_CYCLES, 12, idle cycles in GAP after each frame's eop (min 1)
TIMEOUT, 4096, max cycles in WAIT_SOP or WAIT_EOP before abort
PW, 4, width of each pending counter (saturates at 2^PW-1)

Ports:
clk  in  1  system clock
srst  in  1  synchronous reset, active-high
req_arp  in  1  ARP frame request pulse, one request per high cycle
req_udp1  in  1  UDP1 frame request pulse
req_udp2  in  1  UDP2 frame request pulse
tx_rdy  in  1  MAC ready
tx_wren  in  1  MAC-side TX write enable (monitored)
tx_sop  in  1  MAC-side start of packet (monitored)
tx_eop  in  1  MAC-side end of packet (monitored)
en_arp  out  1  one-cycle start pulse to arbiter / ARP source
en_udp1  out  1  one-cycle start pulse, UDP1
en_udp2  out  1  one-cycle start pulse, UDP2
grant  out  2  active source: 0 none, 1 ARP, 2 UDP1, 3 UDP2
busy  out  1  high whenever state is not IDLE
timeout_err  out  1  one-cycle pulse on WAIT_SOP/WAIT_EOP timeout
req_drop  out  1  one-cycle pulse when a request hits a saturated counter
frames_arp, frames_udp1, frames_udp2  out  16 each  completed-frame counters (see Optional Feature)

Behaviour:
- Reset (srst high at a clk edge): state IDLE; all pending counters, the timer, and the rr flag are 0. All outputs are 0. Reset mid-frame abandons the frame and issues no pulses.
- All outputs are registered.
- Pending counters:
  - A request increments its counter. A request at 2^PW-1 leaves the counter unchanged and pulses req_drop.
  - An issue decrements the counter. A request and an issue for the same source in the same cycle leave the count unchanged.
- States: IDLE, WAIT_SOP, WAIT_EOP, GAP.
- IDLE:
  - Selection happens only if tx_rdy=1 and at least one counter is nonzero.
  - Priority: ARP first. Otherwise, if both UDP counters are nonzero, pick the UDP source opposite rr. Otherwise pick the only nonzero UDP counter.
  - On selection, assert the matching en_* for exactly one cycle, set grant, decrement that counter, set rr to the chosen UDP source (rr unchanged for ARP), clear the timer, and go to WAIT_SOP.
- WAIT_SOP:
  - tx_wren&tx_sop&tx_eop → GAP (single-beat frame).
  - tx_wren&tx_sop → WAIT_EOP.
  - Stray eop is ignored.
- WAIT_EOP:
  - tx_wren&tx_eop → GAP.
  - A further sop is ignored.
- Timer: increments in WAIT_SOP and WAIT_EOP. Reaching TIMEOUT pulses timeout_err and forces GAP; the frame is not counted.
- GAP: grant=0. Counts IFG_CYCLES cycles, then → IDLE.
- Latency: req_x high at edge k, state IDLE, tx_rdy=1, no higher-priority pending → en_x high between edges k+1 and k+2.
- grant holds its value from issue until GAP entry.
- tx_rdy low in IDLE stalls selection only; it is ignored in other states.

Optional Feature:
UDP_TX_SCHED_STATS_EN.
- Defined: frames_* increment by 1 on every eop-terminated completion for the granted source. They wrap 0xFFFF→0 and are cleared by srst.
- Undefined: the frames_* ports remain and are driven constant 0; no counter logic is built.

Test Plan:
- Single req_udp1 pulse at edge 20, tx_rdy=1, bench emits sop at +3, eop at +35 → en_udp1 high in cycle 21 only, grant=2 until eop, busy low exactly 12 cycles after eop.
- req_udp1, req_udp2, req_arp all pulsed in the same cycle → issue order ARP, UDP1, UDP2 (rr initially selects UDP1), each separated by full frame + 12-cycle gap.
- 17 req_udp2 pulses while busy with PW=4 → pending saturates at 15, exactly 2 req_drop pulses, then exactly 15 en_udp2 pulses follow.
- Issue with no sop from the bench (TIMEOUT=64) → timeout_err pulses 64 cycles after en, GAP entered, next pending request served; with STATS_EN, frames_* unchanged.
- srst raised during WAIT_EOP with 3 pending → next cycle all counters 0, grant=0, busy=0, and no en_* pulse ever follows.
- tx_rdy held 0 with pending ARP → no en_arp; tx_rdy rises at edge m → en_arp high between edges m+1 and m+2. Single-beat sop+eop frame → GAP directly; with STATS_EN, frames_arp=1.
